// File: rtl/call_req_encoder.sv
// Elevator call front end: sync + debounce buttons, latch pending calls, serialise round-robin onto req_code.
// Optional CALL_LAMP_EN adds a registered call_lamp output per floor.
module call_req_encoder #(
    parameter int NUM_FLOORS      = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    output logic [2:0]            req_code,
    output logic [NUM_FLOORS-1:0] pending
`ifdef CALL_LAMP_EN
    ,
    output logic [NUM_FLOORS-1:0] call_lamp
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    if (NUM_FLOORS < 1 || NUM_FLOORS > 7 || DEBOUNCE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("call_req_encoder: NUM_FLOORS must be 1..7, DEBOUNCE_CYCLES and GAP_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } state_t;

    state_t                  state;
    logic [NUM_FLOORS-1:0]   sync_1;
    logic [NUM_FLOORS-1:0]   sync_2;
    logic [NUM_FLOORS-1:0]   deb;
    logic [NUM_FLOORS-1:0]   deb_q;
    logic [CNT_W-1:0]        deb_cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0]   rise;
    logic [NUM_FLOORS-1:0]   clr_mask;
    logic [2:0]              rr_ptr;
    logic [2:0]              win_idx;
    logic [2:0]              win_q;
    logic                    win_found;
    logic [3:0]              scan;
    logic [GAP_W-1:0]        gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // A level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync_2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_MAX) begin
                    deb[i]     <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = deb & ~deb_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            scan = {1'b0, rr_ptr} + 4'(k);
            if (scan >= 4'(NUM_FLOORS)) begin
                scan = scan - 4'(NUM_FLOORS);
            end
            if (!win_found && pending[scan[2:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[2:0];
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (state == IDLE && win_found) begin
            clr_mask[win_idx] = 1'b1;
        end
    end

    // A new press landing on the same cycle as its clear wins, so it is served again later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_code <= 3'd0;
            rr_ptr   <= 3'd0;
            win_q    <= 3'd0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_code <= 3'd0;
                    if (win_found) begin
                        state  <= EMIT;
                        win_q  <= win_idx;
                        rr_ptr <= (win_idx == 3'(NUM_FLOORS - 1)) ? 3'd0 : win_idx + 3'd1;
                    end
                end
                EMIT: begin
                    req_code <= win_q + 3'd1;
                    gap_cnt  <= GAP_LOAD;
                    state    <= GAP;
                end
                GAP: begin
                    req_code <= 3'd0;
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    req_code <= 3'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef CALL_LAMP_EN
    logic [NUM_FLOORS-1:0] lamp_r;
    logic [NUM_FLOORS-1:0] served;

    // Lamp stays lit until the call has been sent out and the button is let go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_r <= '0;
            served <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (rise[i]) begin
                    lamp_r[i] <= 1'b1;
                    served[i] <= 1'b0;
                end else begin
                    if (state == EMIT && win_q == 3'(i)) begin
                        served[i] <= 1'b1;
                    end
                    if (lamp_r[i] && served[i] && !deb[i]) begin
                        lamp_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign call_lamp = lamp_r;
`endif

endmodule

// File: tb/tb_call_req_encoder.sv
// Self-checking bench for call_req_encoder (NUM_FLOORS=5, DEBOUNCE_CYCLES=4, GAP_CYCLES=2).
// Table-driven single-window vectors plus hand sequences for reset, round-robin and merge.
module tb_call_req_encoder;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic [2:0] req_code;
    logic [4:0] pending;
`ifdef CALL_LAMP_EN
    logic [4:0] call_lamp;
`endif

    int tests;
    int fails;

    logic [2:0] obs_code [8];
    int         obs_cyc  [8];
    int         obs_n;
    logic [4:0] pend_at  [64];
`ifdef CALL_LAMP_EN
    logic [4:0] lamp_at  [64];
`endif

    typedef struct {
        logic [4:0]      btn;
        int              hold;
        logic [4:0]      pend7;
        int              n;
        logic [4:0][2:0] codes;
    } vec_t;

    vec_t vecs [7];

    call_req_encoder #(
        .NUM_FLOORS(5),
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .req_code(req_code),
        .pending(pending)
`ifdef CALL_LAMP_EN
        ,
        .call_lamp(call_lamp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        btn   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Cycle c is the interval after the c-th rising edge following the call; btn first changes in cycle 0.
    task automatic applyStimulus(input logic [4:0] b, input int hold, input logic [4:0] gmask,
                                 input int gfrom, input int gto, input int ncyc);
        obs_n = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            logic [4:0] cur;
            cur = (c < hold) ? b : 5'b0;
            if (c >= gfrom && c < gto) begin
                cur = cur & ~gmask;
            end
            btn = cur;
            @(negedge clk);
            pend_at[c] = pending;
`ifdef CALL_LAMP_EN
            lamp_at[c] = call_lamp;
`endif
            if (req_code != 3'd0) begin
                if (obs_n < 8) begin
                    obs_code[obs_n] = req_code;
                    obs_cyc[obs_n]  = c;
                end
                obs_n++;
            end
            @(posedge clk);
            #1;
        end
        btn = '0;
    endtask

    task automatic checkCodes(input string tag, input int n, input logic [4:0][2:0] codes, input int first);
        checkOutput($sformatf("%s ncodes", tag), obs_n, n);
        for (int k = 0; k < n && k < obs_n; k++) begin
            checkOutput($sformatf("%s code%0d", tag, k), int'(obs_code[k]), int'(codes[k]));
            checkOutput($sformatf("%s cyc%0d", tag, k), obs_cyc[k], first + 4 * k);
        end
    endtask

    initial begin
        logic [4:0][2:0] cs;
        tests = 0;
        fails = 0;
        btn   = '0;
        rst_n = 1'b0;

        vecs[0] = '{btn: 5'b00100, hold: 10, pend7: 5'b00100, n: 1, codes: '0};
        vecs[0].codes[0] = 3'd3;
        vecs[1] = '{btn: 5'b00010, hold: 3,  pend7: 5'b00000, n: 0, codes: '0};
        vecs[2] = '{btn: 5'b10011, hold: 20, pend7: 5'b10011, n: 3, codes: '0};
        vecs[2].codes[0] = 3'd1;
        vecs[2].codes[1] = 3'd2;
        vecs[2].codes[2] = 3'd5;
        vecs[3] = '{btn: 5'b00001, hold: 10, pend7: 5'b00001, n: 1, codes: '0};
        vecs[3].codes[0] = 3'd1;
        vecs[4] = '{btn: 5'b10000, hold: 10, pend7: 5'b10000, n: 1, codes: '0};
        vecs[4].codes[0] = 3'd5;
        vecs[5] = '{btn: 5'b01000, hold: 4,  pend7: 5'b01000, n: 1, codes: '0};
        vecs[5].codes[0] = 3'd4;
        vecs[6] = '{btn: 5'b11111, hold: 30, pend7: 5'b11111, n: 5, codes: '0};
        for (int k = 0; k < 5; k++) begin
            vecs[6].codes[k] = 3'(k + 1);
        end

        @(negedge clk);
        checkOutput("reset req_code", int'(req_code), 0);
        checkOutput("reset pending", int'(pending), 0);

        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v].btn, vecs[v].hold, 5'b0, 0, 0, 40);
            checkOutput($sformatf("vec%0d pend6", v), int'(pend_at[6]), 0);
            checkOutput($sformatf("vec%0d pend7", v), int'(pend_at[7]), int'(vecs[v].pend7));
            checkCodes($sformatf("vec%0d", v), vecs[v].n, vecs[v].codes, 9);
        end

        // Reset while a code is on the wire and another call is still pending.
        doReset();
        @(posedge clk);
        #1;
        btn = 5'b10011;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("rst pre code", int'(req_code), 1);
        checkOutput("rst pre pending", int'(pending), int'(5'b10010));
        rst_n = 1'b0;
        btn   = '0;
        #1;
        checkOutput("rst async code", int'(req_code), 0);
        checkOutput("rst async pending", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'b0, 0, 5'b0, 0, 0, 30);
        checkOutput("rst post ncodes", obs_n, 0);

        // Round-robin: after floor 2 is served, floors 1 and 3 together go out as 3 then 1.
        doReset();
        applyStimulus(5'b00010, 10, 5'b0, 0, 0, 20);
        cs = '0;
        cs[0] = 3'd2;
        checkCodes("rr first", 1, cs, 9);
        applyStimulus(5'b00101, 10, 5'b0, 0, 0, 30);
        cs[0] = 3'd3;
        cs[1] = 3'd1;
        checkCodes("rr second", 2, cs, 9);

        // Merge: floor 5 is released and pressed again while still queued behind floors 1-4.
        doReset();
        applyStimulus(5'b11111, 30, 5'b10000, 8, 13, 40);
        for (int k = 0; k < 5; k++) begin
            cs[k] = 3'(k + 1);
        end
        checkCodes("merge", 5, cs, 9);
        checkOutput("merge pend20", int'(pend_at[20]), int'(5'b10000));
        checkOutput("merge pend24", int'(pend_at[24]), 0);

`ifdef CALL_LAMP_EN
        doReset();
        applyStimulus(5'b00001, 20, 5'b0, 0, 0, 40);
        checkOutput("lamp c6", int'(lamp_at[6]), 0);
        checkOutput("lamp c7", int'(lamp_at[7]), 1);
        checkOutput("lamp c24", int'(lamp_at[24]), 1);
        checkOutput("lamp c30", int'(lamp_at[30]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
